// File: rtl/pool1_pkg.sv
// Shared types and helpers for the pool-1 control slice.
// FSM states, output-size helper and stride-2 window predicate.
package pool1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  function automatic int next_size(int size, int k);
    return (size - k) / 2 + 1;
  endfunction

  // Pixel (r,c) closes a stride-2 window of size k.
  function automatic logic window_valid(int r, int c, int k);
    return (r >= k - 1) && (c >= k - 1) &&
           (((r - (k - 1)) % 2) == 0) &&
           (((c - (k - 1)) % 2) == 0);
  endfunction

endpackage

// File: rtl/pool1_delay_line.sv
// N-stage valid-bit shift register with asynchronous reset.
// Carries no data, only the strobe being delayed.
module pool1_delay_line #(
  parameter int N = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/pool1_ctrl.sv
// Pool-1 control/address generator: streams IFM pixels, strobes pooling, writes OFM.
// Optional input stall is enabled by defining POOL1_CTRL_STALL_EN.
module pool1_ctrl
  import pool1_pkg::*;
#(
  parameter int IFM_SIZE              = 14,
  parameter int IFM_DEPTH             = 3,
  parameter int KERNAL_SIZE           = 2,
  parameter int IFM_SIZE_NEXT         = next_size(IFM_SIZE, KERNAL_SIZE),
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int POOL_LATENCY          = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
`ifdef POOL1_CTRL_STALL_EN
  input  logic                             stall,
`endif
  output logic                             ifm_rd_en,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_rd_addr,
  output logic [$clog2(IFM_DEPTH):0]       ifm_sel,
  output logic                             fifo_enable,
  output logic                             pool_enable,
  output logic                             ofm_wr_en,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_wr_addr,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = $clog2(IFM_SIZE);
  localparam int SW = $clog2(IFM_DEPTH) + 1;
  localparam int NW = ADDRESS_SIZE_NEXT_IFM;
  localparam int DW = $clog2(POOL_LATENCY + 2) + 1;

  localparam logic [CW-1:0] LAST_IDX   = CW'(IFM_SIZE - 1);
  localparam logic [SW-1:0] LAST_MAP   = SW'(IFM_DEPTH - 1);
  localparam logic [NW-1:0] LAST_WR    = NW'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(POOL_LATENCY + 1);

  state_t        state;
  logic [CW-1:0] r, c, r_q, c_q;
  logic [DW-1:0] drain_cnt;
  logic          rd_q;
  logic          hold;
  logic          last_px;

`ifdef POOL1_CTRL_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign ifm_rd_en = rd_q & ~hold;
  assign last_px   = (r == LAST_IDX) && (c == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      r           <= '0;
      c           <= '0;
      ifm_sel     <= '0;
      ifm_rd_addr <= '0;
      rd_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= STREAM;
            busy        <= 1'b1;
            rd_q        <= 1'b1;
            r           <= '0;
            c           <= '0;
            ifm_sel     <= '0;
            ifm_rd_addr <= '0;
          end
        end
        STREAM: begin
          if (!hold) begin
            if (last_px) begin
              r           <= '0;
              c           <= '0;
              ifm_rd_addr <= '0;
              if (ifm_sel == LAST_MAP) begin
                state     <= DRAIN;
                rd_q      <= 1'b0;
                drain_cnt <= '0;
              end else begin
                ifm_sel <= ifm_sel + 1'b1;
              end
            end else begin
              ifm_rd_addr <= ifm_rd_addr + 1'b1;
              if (c == LAST_IDX) begin
                c <= '0;
                r <= r + 1'b1;
              end else begin
                c <= c + 1'b1;
              end
            end
          end
        end
        // Fixed drain: RAM stage, pool stage, then POOL_LATENCY write stages.
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ifm_sel <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
    end else if (ifm_rd_en) begin
      r_q <= r;
      c_q <= c;
    end
  end

  pool1_delay_line #(.N(1)) u_ram_lat (
    .clk (clk),
    .rst (reset),
    .d   (ifm_rd_en),
    .q   (fifo_enable)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pool_enable <= 1'b0;
    else pool_enable <= fifo_enable &&
      window_valid(int'(r_q), int'(c_q), KERNAL_SIZE);
  end

  pool1_delay_line #(.N(POOL_LATENCY)) u_pool_lat (
    .clk (clk),
    .rst (reset),
    .d   (pool_enable),
    .q   (ofm_wr_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ofm_wr_addr <= '0;
    end else if (state == IDLE && start) begin
      ofm_wr_addr <= '0;
    end else if (ofm_wr_en) begin
      ofm_wr_addr <= (ofm_wr_addr == LAST_WR) ? '0 : ofm_wr_addr + 1'b1;
    end
  end

endmodule
